// File: rtl/hour_clock_ctrl.sv
// Sequencer for a 12-hour wall clock: seconds prescaler, sec/min/pm registers,
// set-mode FSM, and command decode for the external 1..12 hour counter.
module hour_clock_ctrl #(
  parameter int TICKS_PER_SEC = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic       clear_btn,
  input  logic [3:0] hour_q,
  output logic       hour_en,
  output logic       hour_rst,
  output logic       hour_load,
  output logic [3:0] hour_d,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       pm,
  output logic       tick,
  output logic [1:0] state
);

  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    SET_HOUR = 2'd2,
    SET_MIN  = 2'd3
  } state_t;

  state_t        cur, nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic [5:0]    sec_nxt, min_nxt;
  logic          pm_nxt;

  assign state = cur;

  always_ff @(posedge clk) begin
    if (reset) begin
      cur   <= INIT;
      presc <= '0;
      sec   <= '0;
      min   <= '0;
      pm    <= 1'b0;
    end else begin
      cur   <= nxt;
      presc <= presc_nxt;
      sec   <= sec_nxt;
      min   <= min_nxt;
      pm    <= pm_nxt;
    end
  end

  always_comb begin
    nxt       = cur;
    presc_nxt = presc;
    sec_nxt   = sec;
    min_nxt   = min;
    pm_nxt    = pm;
    hour_en   = 1'b0;
    hour_rst  = 1'b0;
    hour_load = 1'b0;
    hour_d    = 4'd0;
    tick      = 1'b0;

    case (cur)
      INIT: begin
        hour_en   = 1'b1;
        hour_load = 1'b1;
        hour_d    = 4'd12;
        presc_nxt = '0;
        sec_nxt   = '0;
        nxt       = RUN;
      end
      RUN: begin
        tick = (presc == PRESC_MAX);
        if (tick) begin
          presc_nxt = '0;
          if (sec == 6'd59) begin
            sec_nxt = '0;
            if (min == 6'd59) begin
              min_nxt = '0;
              hour_en = 1'b1;
            end else begin
              min_nxt = min + 6'd1;
            end
          end else begin
            sec_nxt = sec + 6'd1;
          end
        end else begin
          presc_nxt = presc + 1'b1;
        end
        // Leaving RUN keeps any minute/hour carry from a coincident tick.
        if (mode_btn) begin
          nxt       = SET_HOUR;
          presc_nxt = '0;
          sec_nxt   = '0;
        end
      end
      SET_HOUR: begin
        presc_nxt = '0;
        sec_nxt   = '0;
        if (mode_btn) begin
          nxt = SET_MIN;
        end else if (clear_btn) begin
          hour_en  = 1'b1;
          hour_rst = 1'b1;
          min_nxt  = '0;
          pm_nxt   = 1'b0;
        end else if (inc_btn) begin
          hour_en = 1'b1;
        end
      end
      default: begin
        presc_nxt = '0;
        sec_nxt   = '0;
        if (mode_btn) begin
          nxt = RUN;
        end else if (clear_btn) begin
          hour_en  = 1'b1;
          hour_rst = 1'b1;
          min_nxt  = '0;
          pm_nxt   = 1'b0;
        end else if (inc_btn) begin
          min_nxt = (min == 6'd59) ? 6'd0 : min + 6'd1;
        end
      end
    endcase

    // An advance from 11 crosses noon/midnight.
    if (hour_en && !hour_rst && !hour_load && hour_q == 4'd11)
      pm_nxt = ~pm;

    if (reset) begin
      hour_en   = 1'b1;
      hour_rst  = 1'b0;
      hour_load = 1'b1;
      hour_d    = 4'd12;
      tick      = 1'b0;
    end
  end

endmodule

// File: tb/tb_hour_clock_ctrl.sv
// Bench for hour_clock_ctrl: directed vector table, hand sequences, and random
// button traffic checked against a time-of-day model (seconds since midnight).
module tb_hour_clock_ctrl;
  localparam int T = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mode_btn = 1'b0, inc_btn = 1'b0, clear_btn = 1'b0;
  logic [3:0] hq = 4'd7;
  logic       hour_en, hour_rst, hour_load, pm, tick;
  logic [3:0] hour_d;
  logic [5:0] min, sec;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  hour_clock_ctrl #(.TICKS_PER_SEC(T)) dut (
    .clk(clk), .reset(reset), .mode_btn(mode_btn), .inc_btn(inc_btn),
    .clear_btn(clear_btn), .hour_q(hq), .hour_en(hour_en), .hour_rst(hour_rst),
    .hour_load(hour_load), .hour_d(hour_d), .min(min), .sec(sec), .pm(pm),
    .tick(tick), .state(state)
  );

  always #5 clk = ~clk;

  // Hour counter the controller drives (no reset of its own).
  always @(posedge clk) begin
    if (hour_en) begin
      if (hour_rst)       hq <= 4'd1;
      else if (hour_load) hq <= hour_d;
      else                hq <= (hq == 4'd12) ? 4'd1 : hq + 4'd1;
    end
  end

  // Reference model: mode, seconds since midnight, prescaler phase.
  int  m_mode = 0;
  int  m_t = 0;
  int  m_p = 0;
  bit  m_valid = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int hour_of(input int t);
    int h;
    h = (t / 3600) % 12;
    return (h == 0) ? 12 : h;
  endfunction

  function automatic bit m_tick();
    return !reset && m_mode == 1 && m_p == T - 1;
  endfunction

  task automatic model_check();
    logic [6:0] exp_cmd;
    logic [6:0] act_cmd;
    if (!m_valid) return;
    exp_cmd = 7'd0;
    if (reset || m_mode == 0)
      exp_cmd = {1'b1, 1'b0, 1'b1, 4'd12};
    else if (m_mode == 1)
      exp_cmd = {(m_tick() && (m_t % 3600) == 3599), 6'd0};
    else if (!mode_btn && clear_btn)
      exp_cmd = {1'b1, 1'b1, 1'b0, 4'd0};
    else if (m_mode == 2 && !mode_btn && inc_btn)
      exp_cmd = {1'b1, 6'd0};
    act_cmd = {hour_en, hour_rst, hour_load, hour_d};
    check("state", int'(state), m_mode);
    check("sec", int'(sec), m_t % 60);
    check("min", int'(min), (m_t / 60) % 60);
    check("pm", int'(pm), m_t / 43200);
    check("tick", int'(tick), int'(m_tick()));
    check("hour_q", int'(hq), hour_of(m_t));
    check("cmd", int'(act_cmd), int'(exp_cmd));
  endtask

  task automatic model_update();
    int mn;
    if (reset) begin
      m_mode = 0; m_t = 0; m_p = 0; m_valid = 1'b1;
      return;
    end
    case (m_mode)
      0: begin m_mode = 1; m_p = 0; end
      1: begin
        if (m_tick()) begin m_t = (m_t + 1) % 86400; m_p = 0; end
        else m_p = m_p + 1;
        if (mode_btn) begin m_mode = 2; m_p = 0; m_t = m_t - (m_t % 60); end
      end
      2: begin
        if (mode_btn) m_mode = 3;
        else if (clear_btn) m_t = 3600;
        else if (inc_btn) m_t = (m_t + 3600) % 86400;
      end
      default: begin
        if (mode_btn) begin m_mode = 1; m_p = 0; end
        else if (clear_btn) m_t = 3600;
        else if (inc_btn) begin
          mn = (m_t / 60) % 60;
          m_t = m_t - mn * 60 + ((mn + 1) % 60) * 60;
        end
      end
    endcase
  endtask

  task automatic drive(input bit r, input bit m, input bit i, input bit c);
    @(negedge clk);
    reset = r; mode_btn = m; inc_btn = i; clear_btn = c;
    #1;
    model_check();
  endtask

  task automatic finish_cycle();
    model_update();
    @(posedge clk);
  endtask

  task automatic cyc(input bit r, input bit m, input bit i, input bit c);
    drive(r, m, i, c);
    finish_cycle();
  endtask

  task automatic repeat_cyc(input int n, input bit m, input bit i, input bit c);
    for (int k = 0; k < n; k++) cyc(1'b0, m, i, c);
  endtask

  // Post-edge look at registered values.
  task automatic look(input string tag, input int st, input int hr, input int mn,
                      input int sc, input int p);
    #1;
    check({tag, ".state"}, int'(state), st);
    check({tag, ".hour"}, int'(hq), hr);
    check({tag, ".min"}, int'(min), mn);
    check({tag, ".sec"}, int'(sec), sc);
    check({tag, ".pm"}, int'(pm), p);
  endtask

  typedef struct {
    int r, m, i, c, chk;
    int st, mn, sc, p, hr, tk, ld;
  } vec_t;

  function automatic vec_t mk(input int r, input int chk, input int st, input int sc,
                              input int tk, input int ld);
    vec_t v;
    v.r = r; v.m = 0; v.i = 0; v.c = 0; v.chk = chk;
    v.st = st; v.mn = 0; v.sc = sc; v.p = 0; v.hr = 12; v.tk = tk; v.ld = ld;
    return v;
  endfunction

  vec_t tbl[13];

  initial begin
    tbl[0]  = mk(1, 0, 0, 0, 0, 1);
    tbl[1]  = mk(1, 1, 0, 0, 0, 1);
    tbl[2]  = mk(1, 1, 0, 0, 0, 1);
    tbl[3]  = mk(0, 1, 0, 0, 0, 1);
    tbl[4]  = mk(0, 1, 1, 0, 0, 0);
    tbl[5]  = mk(0, 1, 1, 0, 0, 0);
    tbl[6]  = mk(0, 1, 1, 0, 0, 0);
    tbl[7]  = mk(0, 1, 1, 0, 1, 0);
    tbl[8]  = mk(0, 1, 1, 1, 0, 0);
    tbl[9]  = mk(0, 1, 1, 1, 0, 0);
    tbl[10] = mk(0, 1, 1, 1, 0, 0);
    tbl[11] = mk(0, 1, 1, 1, 1, 0);
    tbl[12] = mk(0, 1, 1, 2, 0, 0);

    // Reset release and first ticks.
    for (int k = 0; k < 13; k++) begin
      drive(tbl[k].r[0], tbl[k].m[0], tbl[k].i[0], tbl[k].c[0]);
      if (tbl[k].chk != 0) begin
        check("vec.state", int'(state), tbl[k].st);
        check("vec.hour", int'(hq), tbl[k].hr);
        check("vec.min", int'(min), tbl[k].mn);
        check("vec.sec", int'(sec), tbl[k].sc);
        check("vec.pm", int'(pm), tbl[k].p);
        check("vec.tick", int'(tick), tbl[k].tk);
        check("vec.load", int'(hour_load), tbl[k].ld);
      end
      finish_cycle();
    end

    // AM/PM through SET_HOUR.
    cyc(0, 1, 0, 0);
    look("enter_set_hour", 2, 12, 0, 0, 0);
    repeat_cyc(11, 0, 1, 0);
    look("inc11", 2, 11, 0, 0, 0);
    cyc(0, 0, 1, 0);
    look("inc12", 2, 12, 0, 0, 1);
    repeat_cyc(12, 0, 1, 0);
    look("inc24", 2, 12, 0, 0, 0);

    // mode beats inc in the same cycle.
    cyc(0, 1, 1, 0);
    look("mode_inc", 3, 12, 0, 0, 0);

    // Clear in SET_MIN from 7:42 PM, then clear ignored in RUN.
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    repeat_cyc(19, 0, 1, 0);
    cyc(0, 1, 0, 0);
    repeat_cyc(42, 0, 1, 0);
    look("pre_clear", 3, 7, 42, 0, 1);
    cyc(0, 0, 0, 1);
    look("clear", 3, 1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 1);
    look("clear_run", 1, 1, 0, 0, 0);

    // 12:59:00 AM -> 60 ticks -> 1:00:00 AM.
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 1);
    repeat_cyc(23, 0, 1, 0);
    cyc(0, 1, 0, 0);
    repeat_cyc(59, 0, 1, 0);
    cyc(0, 1, 0, 0);
    look("carry_start", 1, 12, 59, 0, 0);
    repeat_cyc(59 * T, 0, 0, 0);
    look("carry_pre", 1, 12, 59, 59, 0);
    repeat_cyc(T - 1, 0, 0, 0);
    drive(0, 0, 0, 0);
    check("carry.tick", int'(tick), 1);
    check("carry.hour_en", int'(hour_en), 1);
    finish_cycle();
    look("carry_post", 1, 1, 0, 0, 0);

    // Reset during SET_HOUR at hour 5.
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 1);
    repeat_cyc(4, 0, 1, 0);
    look("pre_reset", 2, 5, 0, 0, 0);
    cyc(1, 0, 0, 0);
    look("in_reset", 0, 12, 0, 0, 0);
    cyc(0, 0, 0, 0);
    look("after_init", 1, 12, 0, 0, 0);

    // Random button traffic against the model.
    for (int k = 0; k < 4000; k++) begin
      cyc($urandom_range(199) == 0, $urandom_range(39) == 0,
          $urandom_range(3) == 0, $urandom_range(29) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hour_clock_ctrl.md
# hour_clock_ctrl

Controller that sequences the 1–12 hour counter into a 12-hour wall clock. It owns the seconds prescaler, the seconds and minutes registers and the AM/PM flag, and drives the hour counter's enable/reset/load/d command port. A button-driven set-mode state machine lets the user adjust hours and minutes. It sits between the one-cycle button pulse synchroniser and the hour counter instance.

## Interface
- TICKS_PER_SEC, 100: clk cycles per second; must be ≥2.
- clk  in  1  clock; all logic on rising edge
- reset  in  1  reset, synchronous, active-high
- mode_btn  in  1  one-cycle pulse; cycles through modes
- inc_btn  in  1  one-cycle pulse; increments the selected field
- clear_btn  in  1  one-cycle pulse; clears the time in set modes
- hour_q  in  4  current hour from the counter (1..12)
- hour_en  out  1  counter enable
- hour_rst  out  1  counter reset (hour := 1)
- hour_load  out  1  counter load (hour := hour_d)
- hour_d  out  4  load value; 0 when hour_load=0
- min  out  6  minutes 0..59
- sec  out  6  seconds 0..59
- pm  out  1  0=AM, 1=PM
- tick  out  1  one-cycle pulse per second in RUN
- state  out  2  0=INIT, 1=RUN, 2=SET_HOUR, 3=SET_MIN

## Operation
- Counter contract: on each edge with hour_en=1, hour_rst wins, else hour_load loads hour_d, else hour goes to hour_q+1, wrapping from 12 to 1. The counter has no global reset, so this block initialises it.
- Command outputs are combinational decodes of state, inputs and registers. Commands are asserted in the same cycle as the trigger. hour_q shows the new value one cycle later.
- hour_rst and hour_load are never asserted together, and never asserted without hour_en.
- INIT: hour_en=1, hour_load=1, hour_d=12. Next state is RUN, unconditionally.
- RUN:
  - The prescaler counts 0..TICKS_PER_SEC-1 and wraps to 0. tick=1 when the prescaler equals TICKS_PER_SEC-1.
  - On tick, sec increments. When sec=59 it becomes 0 and min increments.
  - When sec=59 and min=59 on tick, min becomes 0 and hour_en=1 (advance).
  - On any hour advance with hour_q=11, pm toggles.
- SET_HOUR: inc_btn asserts hour_en=1 (advance). pm toggles if hour_q=11.
- SET_MIN: inc_btn sets min := (min=59) ? 0 : min+1. There is no carry into hour.
- Clear: clear_btn in SET_HOUR or SET_MIN asserts hour_en=1 and hour_rst=1, and sets min=0 and pm=0. Ignored in RUN.
- Mode sequence on mode_btn: RUN→SET_HOUR→SET_MIN→RUN.
  - Entering SET_HOUR clears the prescaler and sec to 0.
  - Entering RUN clears the prescaler and sec to 0.
  - The prescaler, sec and tick are frozen at 0 in set modes.
- Same-cycle priority: mode_btn > clear_btn > inc_btn. The lower-priority pulse is dropped, not queued.
- Buttons in INIT are ignored.

## Timing
- Reset values: state=INIT, min=0, sec=0, pm=0, tick=0, prescaler=0.
- While reset is high: hour_en=1, hour_load=1, hour_d=12.
- Reset mid-operation (any state) follows the same behaviour; no partial update survives.
- First cycle after reset falls: INIT, counter loads 12.
- Second cycle after reset falls: state=RUN and hour_q=12.
- First tick is on the TICKS_PER_SEC-th cycle in RUN. Subsequent ticks are exactly TICKS_PER_SEC cycles apart.
- sec, min and pm update on the edge ending the trigger cycle. hour_q updates on the same edge, so they are visible together on the next cycle.
- Hour rollover latency: one cycle from the triggering tick to the new hour_q.

## Test plan
All scenarios use TICKS_PER_SEC=4.
- Reset release: reset held 3 cycles, then released → one INIT cycle with load d=12. Then RUN with hour_q=12, min=0, sec=0, pm=0. tick on RUN cycles 4, 8, 12.
- Minute/hour carry: set min=59, then run 60 ticks → sec 59→0, min=0, hour_q 12→1, pm=0, all on the same edge.
- AM/PM:
  - In SET_HOUR, 11 inc pulses from 12 → hour_q=11, pm=0.
  - A 12th pulse → hour_q=12, pm=1.
  - 12 more pulses → hour_q=12, pm=0.
- Simultaneous events: mode_btn and inc_btn in the same cycle in SET_HOUR → state=SET_MIN, hour_q unchanged, min unchanged.
- Clear: in SET_MIN with hour 7, min 42, pm 1, pulse clear_btn → hour_q=1, min=0, pm=0. clear_btn in RUN → no change.
- Reset mid-set: reset during SET_HOUR with hour_q=5 → INIT, hour_q=12, min=0, pm=0, then RUN.
